// File: rtl/chrono_pkg.sv
// Shared types and constants for the chronometer controller: FSM states, BCD digit limits and widths.
package chrono_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam int         DIGIT_W = 4;
   localparam logic [3:0] LIM_9   = 4'd9;
   localparam logic [3:0] LIM_5   = 4'd5;

   // Two-digit BCD encoding of a 0..99 integer, used for the minute limit compare.
   function automatic logic [7:0] to_bcd2(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counter: synchronous clear, increment enable, wraps to 0 after LIMIT with a carry-out.
module bcd_digit
   import chrono_pkg::*;
#(
   parameter logic [DIGIT_W-1:0] LIMIT = LIM_9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               inc,
   output logic [DIGIT_W-1:0] q,
   output logic               carry
);

   assign carry = inc && (q == LIMIT);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc) begin
         q <= (q == LIMIT) ? '0 : q + 4'd1;
      end
   end

endmodule

// File: rtl/chrono_ctrl.sv
// Run/pause/clear chronometer controller accumulating 10 ms ticks into BCD MM:SS.CC.
// Optional lap-freeze display is enabled by defining CHRONO_LAP_EN.
module chrono_ctrl
   import chrono_pkg::*;
#(
   parameter int MIN_LIMIT    = 59,
   parameter bit STOP_ON_WRAP = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_ss,
   input  logic        btn_clr,
   input  logic        btn_lap,
   input  logic        tick_in,
   output logic        tick_start,
   output logic        tick_stop,
   output logic        running,
   output logic        rollover,
   output logic [23:0] time_bcd
);

   localparam logic [7:0] MIN_LIM_BCD = to_bcd2(MIN_LIMIT);

   state_t     state;
   logic       sat;
   logic [3:0] cs_o, cs_t, sec_o, sec_t, min_o, min_t;
   logic       c_cs_o, c_cs_t, c_sec_o, c_sec_t, c_min_o, unused_carry;
   logic       count_en, at_max, wrap, inc_cs, clr_digits;
   logic [23:0] live;

   assign live     = {min_t, min_o, sec_t, sec_o, cs_t, cs_o};
   assign count_en = (state == RUN) && tick_in && !btn_clr;
   assign at_max   = ({min_t, min_o} == MIN_LIM_BCD) && (sec_t == LIM_5) && (sec_o == LIM_9)
                     && (cs_t == LIM_9) && (cs_o == LIM_9);
   assign wrap     = count_en && at_max;
   // The max value is handled as a whole here, so the digit chain never has to know MIN_LIMIT.
   assign inc_cs     = count_en && !at_max;
   assign clr_digits = btn_clr || (wrap && !STOP_ON_WRAP);

   bcd_digit #(.LIMIT(LIM_9)) u_cs_o  (.clk, .rst_n, .clr(clr_digits), .inc(inc_cs),  .q(cs_o),  .carry(c_cs_o));
   bcd_digit #(.LIMIT(LIM_9)) u_cs_t  (.clk, .rst_n, .clr(clr_digits), .inc(c_cs_o),  .q(cs_t),  .carry(c_cs_t));
   bcd_digit #(.LIMIT(LIM_9)) u_sec_o (.clk, .rst_n, .clr(clr_digits), .inc(c_cs_t),  .q(sec_o), .carry(c_sec_o));
   bcd_digit #(.LIMIT(LIM_5)) u_sec_t (.clk, .rst_n, .clr(clr_digits), .inc(c_sec_o), .q(sec_t), .carry(c_sec_t));
   bcd_digit #(.LIMIT(LIM_9)) u_min_o (.clk, .rst_n, .clr(clr_digits), .inc(c_sec_t), .q(min_o), .carry(c_min_o));
   bcd_digit #(.LIMIT(LIM_9)) u_min_t (.clk, .rst_n, .clr(clr_digits), .inc(c_min_o), .q(min_t), .carry(unused_carry));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         sat        <= 1'b0;
         tick_start <= 1'b0;
         tick_stop  <= 1'b1;
         running    <= 1'b0;
         rollover   <= 1'b0;
      end else begin
         tick_start <= 1'b0;
         rollover   <= wrap;
         if (btn_clr) begin
            state     <= IDLE;
            sat       <= 1'b0;
            tick_stop <= 1'b1;
            running   <= 1'b0;
         end else if (wrap && STOP_ON_WRAP) begin
            state     <= PAUSE;
            sat       <= 1'b1;
            tick_stop <= 1'b1;
            running   <= 1'b0;
         end else if (btn_ss && !sat) begin
            unique case (state)
               RUN: begin
                  state     <= PAUSE;
                  tick_stop <= 1'b1;
                  running   <= 1'b0;
               end
               default: begin
                  state      <= RUN;
                  tick_start <= 1'b1;
                  tick_stop  <= 1'b0;
                  running    <= 1'b1;
               end
            endcase
         end
      end
   end

`ifdef CHRONO_LAP_EN
   logic        freeze;
   logic [23:0] lap_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         freeze <= 1'b0;
      end else if (btn_clr) begin
         freeze <= 1'b0;
      end else if (btn_lap && (state == RUN)) begin
         freeze <= !freeze;
      end
   end

   // NOTE: lap_q is pure data, only visible while freeze is set, so it carries no reset.
   always_ff @(posedge clk) begin
      if (btn_lap && (state == RUN) && !freeze) begin
         lap_q <= live;
      end
   end

   assign time_bcd = freeze ? lap_q : live;
`else
   logic unused_lap;
   assign unused_lap = btn_lap;
   assign time_bcd   = live;
`endif

endmodule

// File: tb/tb_chrono_ctrl.sv
// Directed self-checking bench for chrono_ctrl; two instances (wrap vs. saturate) share stimulus.
module tb_chrono_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, btn_ss, btn_clr, btn_lap, tick_in;
   logic        ts_a, tp_a, run_a, ro_a;
   logic        ts_b, tp_b, run_b, ro_b;
   logic [23:0] t_a, t_b;
   int          n_checks = 0;
   int          n_err    = 0;
   int          ts_seen;

   always #5 clk = ~clk;

   chrono_ctrl #(.MIN_LIMIT(1), .STOP_ON_WRAP(1'b0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_clr(btn_clr), .btn_lap(btn_lap),
      .tick_in(tick_in), .tick_start(ts_a), .tick_stop(tp_a), .running(run_a),
      .rollover(ro_a), .time_bcd(t_a)
   );

   chrono_ctrl #(.MIN_LIMIT(1), .STOP_ON_WRAP(1'b1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_clr(btn_clr), .btn_lap(btn_lap),
      .tick_in(tick_in), .tick_start(ts_b), .tick_stop(tp_b), .running(run_b),
      .rollover(ro_b), .time_bcd(t_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the active edge.
   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (ts_a) ts_seen++;
      end
   endtask

   task automatic ticks(input int n);
      tick_in = 1'b1;
      cycles(n);
      tick_in = 1'b0;
   endtask

   task automatic press_ss();
      btn_ss = 1'b1;
      cycles(1);
      btn_ss = 1'b0;
   endtask

   task automatic press_clr();
      btn_clr = 1'b1;
      cycles(1);
      btn_clr = 1'b0;
   endtask

   task automatic press_lap();
      btn_lap = 1'b1;
      cycles(1);
      btn_lap = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0; tick_in = 1'b0;
      ts_seen = 0;
      cycles(2);
      check("rst_time",  t_a,   24'h000000);
      check("rst_stop",  tp_a,  1'b1);
      check("rst_run",   run_a, 1'b0);
      check("rst_start", ts_a,  1'b0);
      check("rst_roll",  ro_a,  1'b0);
      rst_n = 1'b1;
      cycles(1);

      // Start, 150 ticks: exactly one tick_start, 00:01.50.
      ts_seen = 0;
      press_ss();
      check("t1_tick_start", ts_a, 1'b1);
      check("t1_running",    run_a, 1'b1);
      check("t1_tick_stop",  tp_a, 1'b0);
      ticks(150);
      check("t1_time",       t_a, 24'h000150);
      check("t1_start_cnt",  ts_seen, 1);
      check("t1_b_time",     t_b, 24'h000150);

      // Tick coinciding with btn_ss in RUN is counted, then PAUSE.
      press_clr();
      check("t2_clr_time", t_a, 24'h000000);
      press_ss();
      ticks(5);
      check("t2_pre", t_a, 24'h000005);
      btn_ss = 1'b1; tick_in = 1'b1;
      cycles(1);
      btn_ss = 1'b0; tick_in = 1'b0;
      check("t2_time",    t_a, 24'h000006);
      check("t2_running", run_a, 1'b0);
      check("t2_stop",    tp_a, 1'b1);
      ticks(4);
      check("t2_paused_hold", t_a, 24'h000006);

      // btn_clr beats btn_ss.
      ts_seen = 0;
      btn_ss = 1'b1; btn_clr = 1'b1;
      cycles(1);
      btn_ss = 1'b0; btn_clr = 1'b0;
      check("t3_time",  t_a, 24'h000000);
      check("t3_start", ts_a, 1'b0);
      check("t3_stop",  tp_a, 1'b1);
      check("t3_run",   run_a, 1'b0);
      cycles(2);
      check("t3_start_cnt", ts_seen, 0);

      // Tick discarded when it coincides with btn_clr.
      press_ss();
      ticks(3);
      btn_clr = 1'b1; tick_in = 1'b1;
      cycles(1);
      btn_clr = 1'b0; tick_in = 1'b0;
      check("clr_tick_discard", t_a, 24'h000000);

      // Wrap vs. saturate at MIN_LIMIT=1, i.e. 01:59.99.
      press_ss();
      ticks(11999);
      check("t4_max_a", t_a, 24'h015999);
      check("t4_max_b", t_b, 24'h015999);
      check("t4_noroll", ro_a, 1'b0);
      ticks(1);
      check("t4_wrap_a",  t_a,   24'h000000);
      check("t4_roll_a",  ro_a,  1'b1);
      check("t4_run_a",   run_a, 1'b1);
      check("t4_hold_b",  t_b,   24'h015999);
      check("t4_roll_b",  ro_b,  1'b1);
      check("t4_run_b",   run_b, 1'b0);
      check("t4_stop_b",  tp_b,  1'b1);
      cycles(1);
      check("t4_roll_a_end", ro_a, 1'b0);
      check("t4_roll_b_end", ro_b, 1'b0);
      ticks(3);
      check("t4_after_a", t_a, 24'h000003);
      check("t4_after_b", t_b, 24'h015999);
      press_ss();
      check("t4_sat_ss_start", ts_b, 1'b0);
      check("t4_sat_ss_run",   run_b, 1'b0);
      check("t4_a_paused",     run_a, 1'b0);
      press_clr();
      check("t4_clr_b", t_b, 24'h000000);

      // Lap freeze (ignored when the feature is compiled out).
      press_ss();
      ticks(100);
      check("t5_pre", t_a, 24'h000100);
      press_lap();
      ticks(50);
`ifdef CHRONO_LAP_EN
      check("t5_frozen", t_a, 24'h000100);
`else
      check("t5_live",   t_a, 24'h000150);
`endif
      press_lap();
      check("t5_unfrozen", t_a, 24'h000150);

      // Reset mid-RUN (with a lap frozen when enabled).
      press_clr();
      press_ss();
      ticks(1234);
      check("t6_pre", t_a, 24'h001234);
      press_lap();
      ticks(2);
      rst_n = 1'b0;
      cycles(1);
      rst_n = 1'b1;
      check("t6_time", t_a,   24'h000000);
      check("t6_stop", tp_a,  1'b1);
      check("t6_run",  run_a, 1'b0);
      press_ss();
      ticks(1);
      check("t6_unfrozen", t_a, 24'h000001);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
